// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and memory-side signal bundle for dmem_arbiter
interface dmem_arbiter_if #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int BURST_MAX = 8,
    parameter int LEN_W     = $clog2(BURST_MAX + 1)
);
    logic              switchStart;
    logic              r0_req;
    logic              r0_we;
    logic [ADDR_W-1:0] r0_addr;
    logic [DATA_W-1:0] r0_wd;
    logic              r0_gnt;
    logic              r0_rvalid;
    logic [DATA_W-1:0] r0_rdata;
    logic              r0_err;
    logic              r1_req;
    logic              r1_we;
    logic [ADDR_W-1:0] r1_addr;
    logic [LEN_W-1:0]  r1_len;
    logic              r1_gnt;
    logic              r1_wvalid;
    logic [DATA_W-1:0] r1_wd;
    logic              r1_wready;
    logic              r1_rvalid;
    logic [DATA_W-1:0] r1_rdata;
    logic              r1_err;
    logic              r1_done;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    modport slave (
        input  switchStart,
        input  r0_req, r0_we, r0_addr, r0_wd,
        output r0_gnt, r0_rvalid, r0_rdata, r0_err,
        input  r1_req, r1_we, r1_addr, r1_len, r1_wvalid, r1_wd,
        output r1_gnt, r1_wready, r1_rvalid, r1_rdata, r1_err, r1_done,
        output mem_we, mem_addr, mem_wd,
        input  mem_rd
    );

    modport master (
        output switchStart,
        output r0_req, r0_we, r0_addr, r0_wd,
        input  r0_gnt, r0_rvalid, r0_rdata, r0_err,
        output r1_req, r1_we, r1_addr, r1_len, r1_wvalid, r1_wd,
        input  r1_gnt, r1_wready, r1_rvalid, r1_rdata, r1_err, r1_done,
        input  mem_we, mem_addr, mem_wd,
        output mem_rd
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DMA round-robin arbiter and burst sequencer for dmem_ram
module dmem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int BURST_MAX = 8,
    parameter int LEN_W     = $clog2(BURST_MAX + 1)
) (
    input logic          clk,
    input logic          rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t            state;
    logic              rr_ptr;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  b_len;
    logic [ADDR_W-1:0] b_base;
    logic              b_we;

    logic              run;
    logic              r0_gnt_c;
    logic              r1_gnt_c;
    logic              beat;
    logic              last_beat;
    logic              acc;
    logic              acc_we;
    logic              in_range;
    logic [ADDR_W-1:0] beat_addr;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wd;

    // Combinational outputs are gated by rst so an aborted burst stops writing at once.
    always_comb begin
        run       = bus.switchStart & !rst;
        r0_gnt_c  = run & (state == IDLE) & bus.r0_req & (!bus.r1_req | !rr_ptr);
        r1_gnt_c  = run & (state == IDLE) & bus.r1_req & (!bus.r0_req | rr_ptr);
        beat      = run & (state == BURST) & (!b_we | bus.r1_wvalid);
        beat_addr = b_base + ADDR_W'(cnt);
        last_beat = (cnt + LEN_W'(1)) == b_len;
        acc       = r0_gnt_c | beat;
        acc_addr  = r0_gnt_c ? bus.r0_addr : beat_addr;
        acc_we    = r0_gnt_c ? bus.r0_we : b_we;
        acc_wd    = r0_gnt_c ? bus.r0_wd : bus.r1_wd;
        in_range  = acc_addr < ADDR_W'(MEM_DEPTH);
    end

    assign bus.r0_gnt    = r0_gnt_c;
    assign bus.r1_gnt    = r1_gnt_c;
    assign bus.r1_wready = beat & b_we;
    assign bus.mem_we    = acc & acc_we & in_range;
    assign bus.mem_addr  = acc ? acc_addr : '0;
    assign bus.mem_wd    = (acc & acc_we) ? acc_wd : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= 1'b0;
            cnt           <= '0;
            b_len         <= '0;
            b_base        <= '0;
            b_we          <= 1'b0;
            bus.r0_rvalid <= 1'b0;
            bus.r0_rdata  <= '0;
            bus.r0_err    <= 1'b0;
            bus.r1_rvalid <= 1'b0;
            bus.r1_rdata  <= '0;
            bus.r1_err    <= 1'b0;
            bus.r1_done   <= 1'b0;
        end else begin
            bus.r0_rvalid <= r0_gnt_c & !bus.r0_we;
            bus.r0_rdata  <= (r0_gnt_c & !bus.r0_we & in_range) ? bus.mem_rd : '0;
            bus.r0_err    <= r0_gnt_c & !in_range;
            bus.r1_rvalid <= beat & !b_we;
            bus.r1_rdata  <= (beat & !b_we & in_range) ? bus.mem_rd : '0;
            bus.r1_err    <= beat & !in_range;
            bus.r1_done   <= (r1_gnt_c & (bus.r1_len == '0)) | (beat & last_beat);

            // A lone CPU grant keeps the pointer; contested grants point it at the loser.
            if (r0_gnt_c & bus.r1_req)
                rr_ptr <= 1'b1;

            if (r1_gnt_c) begin
                if (bus.r0_req)
                    rr_ptr <= 1'b0;
                b_base <= bus.r1_addr;
                b_len  <= bus.r1_len;
                b_we   <= bus.r1_we;
                cnt    <= '0;
                if (bus.r1_len != '0)
                    state <= BURST;
            end

            if (beat) begin
                if (last_beat) begin
                    state  <= IDLE;
                    cnt    <= '0;
                    rr_ptr <= 1'b0;
                end else begin
                    cnt <= cnt + LEN_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;
    int   wr_base;
    bit   loaded = 1'b0;
    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    dmem_arbiter_if bus ();

    dmem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mem_rd = mem[bus.mem_addr[9:0]];

    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
            mem[0] = 32'h1111_1111;
            mem[1] = 32'h2222_2222;
            for (int i = 0; i < 4; i++) mem[100 + i] = 32'hA5A5_0000 + 32'(i);
            mem[1022] = 32'hC0DE_0000;
            mem[1023] = 32'hC0DE_0001;
            loaded = 1'b1;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[9:0]] = bus.mem_wd;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.switchStart = 1'b1;
        bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_addr = 32'd5; bus.r0_wd = 32'h0;
        bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_addr = 32'h0; bus.r1_len = 4'd0;
        bus.r1_wvalid = 1'b0; bus.r1_wd = 32'h0;
        next(); next();
        chk("rst_r0_gnt", 32'(bus.r0_gnt), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_r1_done", 32'(bus.r1_done), 32'd0);
        chk("rst_r0_rvalid", 32'(bus.r0_rvalid), 32'd0);
        rst = 1'b0;

        // CPU write then read-back
        bus.r0_wd = 32'hDEAD_BEEF;
        #1;
        chk("cpu_wr_gnt", 32'(bus.r0_gnt), 32'd1);
        chk("cpu_wr_mem_we", 32'(bus.mem_we), 32'd1);
        chk("cpu_wr_mem_addr", bus.mem_addr, 32'd5);
        chk("cpu_wr_mem_wd", bus.mem_wd, 32'hDEAD_BEEF);
        next();
        bus.r0_we = 1'b0;
        #1;
        chk("cpu_rd_gnt", 32'(bus.r0_gnt), 32'd1);
        chk("cpu_rd_mem_we", 32'(bus.mem_we), 32'd0);
        chk("cpu_wr_no_rvalid", 32'(bus.r0_rvalid), 32'd0);
        next();
        bus.r0_req = 1'b0;
        #1;
        chk("cpu_rd_rvalid", 32'(bus.r0_rvalid), 32'd1);
        chk("cpu_rd_rdata", bus.r0_rdata, 32'hDEAD_BEEF);
        chk("cpu_rd_err", 32'(bus.r0_err), 32'd0);
        next();
        chk("cpu_rvalid_pulse", 32'(bus.r0_rvalid), 32'd0);

        // DMA read burst 100..103
        bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 32'd100; bus.r1_len = 4'd4;
        #1;
        chk("dma_rd_gnt", 32'(bus.r1_gnt), 32'd1);
        chk("dma_rd_accept_noacc", bus.mem_addr, 32'd0);
        next();
        bus.r1_req = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("dma_rd_beat_addr", bus.mem_addr, 32'(100 + i));
            next();
            chk("dma_rd_rvalid", 32'(bus.r1_rvalid), 32'd1);
            chk("dma_rd_rdata", bus.r1_rdata, 32'hA5A5_0000 + 32'(i));
            chk("dma_rd_done", 32'(bus.r1_done), (i == 3) ? 32'd1 : 32'd0);
        end
        next();
        chk("dma_rd_rvalid_end", 32'(bus.r1_rvalid), 32'd0);

        // DMA write burst 200..202 with a 2-cycle stall and a waiting CPU
        wr_base = wr_cnt;
        bus.r1_req = 1'b1; bus.r1_we = 1'b1; bus.r1_addr = 32'd200; bus.r1_len = 4'd3;
        #1;
        chk("dma_wr_gnt", 32'(bus.r1_gnt), 32'd1);
        next();
        bus.r1_req = 1'b0; bus.r1_wvalid = 1'b1; bus.r1_wd = 32'hBEEF_0000;
        bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 32'd7;
        #1;
        chk("dma_wr_cpu_blocked", 32'(bus.r0_gnt), 32'd0);
        chk("dma_wr_wready", 32'(bus.r1_wready), 32'd1);
        chk("dma_wr_b0_addr", bus.mem_addr, 32'd200);
        chk("dma_wr_b0_wd", bus.mem_wd, 32'hBEEF_0000);
        for (int i = 0; i < 2; i++) begin
            next();
            bus.r1_wvalid = 1'b0;
            #1;
            chk("dma_wr_stall_wready", 32'(bus.r1_wready), 32'd0);
            chk("dma_wr_stall_mem_we", 32'(bus.mem_we), 32'd0);
            chk("dma_wr_stall_cpu", 32'(bus.r0_gnt), 32'd0);
        end
        next();
        bus.r1_wvalid = 1'b1; bus.r1_wd = 32'hBEEF_0001;
        #1;
        chk("dma_wr_b1_addr", bus.mem_addr, 32'd201);
        next();
        bus.r1_wd = 32'hBEEF_0002;
        #1;
        chk("dma_wr_b2_addr", bus.mem_addr, 32'd202);
        chk("dma_wr_b2_cpu", 32'(bus.r0_gnt), 32'd0);
        next();
        bus.r1_wvalid = 1'b0;
        #1;
        chk("dma_wr_done", 32'(bus.r1_done), 32'd1);
        chk("dma_wr_cpu_gnt", 32'(bus.r0_gnt), 32'd1);
        chk("dma_wr_count", 32'(wr_cnt - wr_base), 32'd3);
        next();
        bus.r0_req = 1'b0;
        chk("dma_wr_mem200", mem[200], 32'hBEEF_0000);
        chk("dma_wr_mem201", mem[201], 32'hBEEF_0001);
        chk("dma_wr_mem202", mem[202], 32'hBEEF_0002);

        // Round-robin after a fresh reset: CPU, DMA, CPU
        rst = 1'b1;
        next();
        rst = 1'b0;
        bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 32'd1;
        bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 32'd0; bus.r1_len = 4'd0;
        #1;
        chk("rr1_cpu", 32'(bus.r0_gnt), 32'd1);
        chk("rr1_dma", 32'(bus.r1_gnt), 32'd0);
        next();
        #1;
        chk("rr2_cpu", 32'(bus.r0_gnt), 32'd0);
        chk("rr2_dma", 32'(bus.r1_gnt), 32'd1);
        chk("rr1_rdata", bus.r0_rdata, 32'h2222_2222);
        next();
        #1;
        chk("rr3_cpu", 32'(bus.r0_gnt), 32'd1);
        chk("rr3_dma", 32'(bus.r1_gnt), 32'd0);
        chk("len0_done", 32'(bus.r1_done), 32'd1);
        next();
        bus.r1_req = 1'b0;
        #1;
        chk("rr_lone_cpu", 32'(bus.r0_gnt), 32'd1);
        next();
        bus.r1_req = 1'b1;
        #1;
        chk("rr_kept_dma", 32'(bus.r1_gnt), 32'd1);
        chk("rr_kept_cpu", 32'(bus.r0_gnt), 32'd0);
        next();
        bus.r0_req = 1'b0; bus.r1_req = 1'b0;
        #1;
        chk("len0_done2", 32'(bus.r1_done), 32'd1);
        chk("len0_no_acc", 32'(bus.mem_we), 32'd0);
        next();

        // Out-of-range CPU accesses
        bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 32'd1024;
        #1;
        chk("oor_cpu_gnt", 32'(bus.r0_gnt), 32'd1);
        next();
        bus.r0_we = 1'b1; bus.r0_addr = 32'd1030; bus.r0_wd = 32'h5555_5555;
        #1;
        chk("oor_cpu_rd_rvalid", 32'(bus.r0_rvalid), 32'd1);
        chk("oor_cpu_rd_rdata", bus.r0_rdata, 32'd0);
        chk("oor_cpu_rd_err", 32'(bus.r0_err), 32'd1);
        chk("oor_cpu_wr_mem_we", 32'(bus.mem_we), 32'd0);
        next();
        bus.r0_req = 1'b0;
        #1;
        chk("oor_cpu_wr_err", 32'(bus.r0_err), 32'd1);
        chk("oor_cpu_wr_rvalid", 32'(bus.r0_rvalid), 32'd0);

        // DMA read burst straddling the top of memory
        bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_addr = 32'd1022; bus.r1_len = 4'd4;
        next();
        bus.r1_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next();
            chk("oor_dma_rvalid", 32'(bus.r1_rvalid), 32'd1);
            chk("oor_dma_rdata", bus.r1_rdata, (i == 0) ? 32'hC0DE_0000 : (i == 1) ? 32'hC0DE_0001 : 32'd0);
            chk("oor_dma_err", 32'(bus.r1_err), (i >= 2) ? 32'd1 : 32'd0);
        end
        next();

        // DMA write burst straddling the top of memory
        bus.r1_req = 1'b1; bus.r1_we = 1'b1; bus.r1_addr = 32'd1023; bus.r1_len = 4'd2;
        bus.r1_wvalid = 1'b1; bus.r1_wd = 32'hD000_0001;
        next();
        bus.r1_req = 1'b0;
        #1;
        chk("oor_dmaw_b0_we", 32'(bus.mem_we), 32'd1);
        next();
        bus.r1_wd = 32'hD000_0002;
        #1;
        chk("oor_dmaw_b1_addr", bus.mem_addr, 32'd1024);
        chk("oor_dmaw_b1_we", 32'(bus.mem_we), 32'd0);
        chk("oor_dmaw_b0_err", 32'(bus.r1_err), 32'd0);
        next();
        bus.r1_wvalid = 1'b0;
        #1;
        chk("oor_dmaw_b1_err", 32'(bus.r1_err), 32'd1);
        chk("oor_dmaw_b1_rvalid", 32'(bus.r1_rvalid), 32'd0);
        chk("oor_dmaw_done", 32'(bus.r1_done), 32'd1);
        chk("oor_dmaw_mem1023", mem[1023], 32'hD000_0001);
        chk("oor_dmaw_mem0", mem[0], 32'h1111_1111);

        // switchStart pause in a 6-beat write burst
        wr_base = wr_cnt;
        bus.r1_req = 1'b1; bus.r1_we = 1'b1; bus.r1_addr = 32'd300; bus.r1_len = 4'd6;
        next();
        bus.r1_req = 1'b0; bus.r1_wvalid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.r1_wd = 32'hB000_0000 + 32'(i);
            #1;
            chk("pause_pre_addr", bus.mem_addr, 32'(300 + i));
            next();
        end
        bus.switchStart = 1'b0;
        bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_addr = 32'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("pause_mem_we", 32'(bus.mem_we), 32'd0);
            chk("pause_wready", 32'(bus.r1_wready), 32'd0);
            chk("pause_cpu_gnt", 32'(bus.r0_gnt), 32'd0);
            next();
        end
        bus.switchStart = 1'b1; bus.r0_req = 1'b0;
        for (int i = 2; i < 6; i++) begin
            bus.r1_wd = 32'hB000_0000 + 32'(i);
            #1;
            chk("pause_post_addr", bus.mem_addr, 32'(300 + i));
            next();
        end
        bus.r1_wvalid = 1'b0;
        chk("pause_done", 32'(bus.r1_done), 32'd1);
        chk("pause_count", 32'(wr_cnt - wr_base), 32'd6);
        chk("pause_mem302", mem[302], 32'hB000_0002);
        chk("pause_mem305", mem[305], 32'hB000_0005);
        next();

        // Reset in the middle of a 6-beat write burst
        wr_base = wr_cnt;
        bus.r1_req = 1'b1; bus.r1_we = 1'b1; bus.r1_addr = 32'd400; bus.r1_len = 4'd6;
        next();
        bus.r1_req = 1'b0; bus.r1_wvalid = 1'b1; bus.r1_wd = 32'h7777_0000;
        for (int i = 0; i < 3; i++) next();
        rst = 1'b1;
        #1;
        chk("abort_mem_we", 32'(bus.mem_we), 32'd0);
        chk("abort_mem_addr", bus.mem_addr, 32'd0);
        chk("abort_wready", 32'(bus.r1_wready), 32'd0);
        chk("abort_done", 32'(bus.r1_done), 32'd0);
        next();
        rst = 1'b0;
        #1;
        chk("abort_idle_mem_we", 32'(bus.mem_we), 32'd0);
        next();
        chk("abort_idle_done", 32'(bus.r1_done), 32'd0);
        chk("abort_count", 32'(wr_cnt - wr_base), 32'd3);
        chk("abort_mem403", mem[403], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
